divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits; all requirements and values below assume WIDTH=32.
REQ-002 The block SHALL have port clk_i, input, 1 bit, single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port dividend_i, input, WIDTH bits, numerator.
REQ-005 The block SHALL have port divisor_i, input, WIDTH bits, denominator.
REQ-006 The block SHALL have port start_i, input, 1 bit, request to begin a division.
REQ-007 The block SHALL have port is_signed_i, input, 1 bit; 1 means operands are two's complement, 0 means unsigned.
REQ-008 The block SHALL have port quotient_o, output, WIDTH bits, result quotient.
REQ-009 The block SHALL have port remainder_o, output, WIDTH bits, result remainder.
REQ-010 The block SHALL have port done_o, output, 1 bit, one-cycle result-valid pulse.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-012 In IDLE, start_i=1 SHALL capture dividend_i, divisor_i and is_signed_i, and move to BUSY; that edge is cycle 0.
REQ-013 start_i SHALL be ignored in BUSY and DONE; a start held high for several cycles starts exactly one division.
REQ-014 Operand inputs SHALL be don't-care after capture.
REQ-015 BUSY SHALL run 32 radix-2 restoring iterations on operand magnitudes, one per cycle, then enter DONE.
REQ-016 In DONE, done_o SHALL be 1 for exactly one cycle (cycle 33 after capture), then the FSM returns to IDLE.
REQ-017 quotient_o/remainder_o SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-018 Signed mode SHALL truncate toward zero; quotient is negative iff operand signs differ; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-019 Divisor zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, in both modes.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-021 Unsigned mode SHALL give floor quotient and modulo remainder of the 32-bit unsigned values.
REQ-022 A start_i arriving in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.

Reset
REQ-023 reset_i=1 SHALL immediately force IDLE, done_o=0, quotient_o=0, remainder_o=0, and clear internal registers, regardless of clock.
REQ-024 Reset mid-division SHALL abort it with no done_o pulse; the first start after reset release is accepted normally.

Configuration
REQ-025 When macro DIVIDER_ZERO_BYPASS_EN is defined, divide-by-zero and signed overflow SHALL skip BUSY and assert done_o at cycle 1 with the REQ-019/REQ-020 results.
REQ-026 When DIVIDER_ZERO_BYPASS_EN is undefined, those cases SHALL take the normal 33-cycle latency with identical results.

Structure
REQ-027 Package divider_pkg SHALL hold the FSM state enum, the WIDTH default and the iteration count constant.
REQ-028 An unsigned iterative sub-module divider_core SHALL handle shift/subtract; divider SHALL handle operand absolute value, result sign correction, special cases and the FSM.

Verification
REQ-029 Signed -103/20 (0xFFFFFF99/0x14) with start held 1.5 cycles SHALL give q=0xFFFFFFFB (-5), r=0xFFFFFFFD (-3), and exactly one done pulse at cycle 33.
REQ-030 Signed -10/-6 SHALL give q=1, r=0xFFFFFFFC (-4); signed 5/-3 SHALL give q=0xFFFFFFFF (-1), r=2.
REQ-031 Unsigned 10/3 SHALL give q=3, r=1; unsigned 0xFFFFFFFF/2 SHALL give q=0x7FFFFFFF, r=1.
REQ-032 Unsigned and signed 7/0 SHALL give q=0xFFFFFFFF, r=7; signed 0x80000000/0xFFFFFFFF SHALL give q=0x80000000, r=0; latency SHALL be checked with and without DIVIDER_ZERO_BYPASS_EN.
REQ-033 reset_i asserted at cycle 10 of a division SHALL zero all outputs immediately with no done pulse; a following 10/3 SHALL give q=3, r=1.
REQ-034 An exhaustive unsigned sweep of dividend 1..15 by divisor 0..15 SHALL match the reference model in every case.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared constants and FSM state type for the iterative divider.
// Holds the default operand width and the per-division iteration count.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Ports: load_i starts a run on dividend_i/divisor_i; ready_o is high
// once all iterations have completed, with quotient_o/remainder_o valid.
module divider_core
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             ready_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] TOTAL = CW'(WIDTH);

    logic [CW-1:0]    count;
    logic             run;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The partial remainder always stays below the divisor (or, for a
    // zero divisor, below 2^k after k steps), so one extra bit suffices.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
            run   <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
        end else if (load_i) begin
            count <= '0;
            run   <= 1'b1;
            quo   <= dividend_i;
            rem   <= '0;
            dsr   <= divisor_i;
        end else if (run) begin
            if (!trial[WIDTH]) begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == LAST) begin
                run <= 1'b0;
            end
        end
    end

    assign quotient_o  = quo;
    assign remainder_o = rem;
    assign ready_o     = !run && (count == TOTAL);

endmodule

// File: rtl/divider.sv
// Signed/unsigned iterative divider: operand magnitudes, sign fix-up,
// divide-by-zero and overflow handling around divider_core, plus the FSM.
// Ports: clk_i, reset_i (async, active high), dividend_i, divisor_i,
// start_i, is_signed_i in; quotient_o, remainder_o, done_o (1-cycle) out.
// Optional: DIVIDER_ZERO_BYPASS_EN finishes zero-divisor and signed
// overflow cases one cycle after capture instead of running the core.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = '1;

    div_state_e       state;
    logic             neg_q;
    logic             neg_r;
    logic             zero_q;
    logic             ovf_q;
    logic [WIDTH-1:0] dvd_q;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             core_load;
    logic             core_ready;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;
    logic             finish;

    always_comb begin
        dvd_neg = is_signed_i & dividend_i[WIDTH-1];
        dsr_neg = is_signed_i & divisor_i[WIDTH-1];
        dvd_mag = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
        dsr_mag = dsr_neg ? (~divisor_i + 1'b1) : divisor_i;
    end

    assign core_load = (state == ST_IDLE) && start_i;

    divider_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (core_load),
        .dividend_i (dvd_mag),
        .divisor_i  (dsr_mag),
        .quotient_o (core_q),
        .remainder_o(core_r),
        .ready_o    (core_ready)
    );

    // Special cases override whatever the core produced.
    always_comb begin
        fin_q = neg_q ? (~core_q + 1'b1) : core_q;
        fin_r = neg_r ? (~core_r + 1'b1) : core_r;
        if (zero_q) begin
            fin_q = ONES;
            fin_r = dvd_q;
        end else if (ovf_q) begin
            fin_q = MIN_VAL;
            fin_r = '0;
        end
    end

`ifdef DIVIDER_ZERO_BYPASS_EN
    assign finish = core_ready | zero_q | ovf_q;
`else
    assign finish = core_ready;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dvd_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        neg_q  <= dvd_neg ^ dsr_neg;
                        neg_r  <= dvd_neg;
                        zero_q <= (divisor_i == '0);
                        ovf_q  <= is_signed_i && (dividend_i == MIN_VAL)
                                  && (divisor_i == ONES);
                        dvd_q  <= dividend_i;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        quotient_o  <= fin_q;
                        remainder_o <= fin_r;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_divider.sv
// Randomized and directed self-checking bench for divider.
// Compares each result, latency and done pulse count to a reference model.
module tb_divider;

`ifdef DIVIDER_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        start_i = 1'b0;
    logic        is_signed_i = 1'b0;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    divider #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .start_i    (start_i),
        .is_signed_i(is_signed_i),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_ovf(input bit s, input logic [31:0] a,
                                  input logic [31:0] b);
        return s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Reference: plain language-level division.
    task automatic ref_div(input bit s, input logic [31:0] a,
                           input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (is_ovf(s, a, b)) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // hold = number of rising edges (from the capture edge) that see start=1
    task automatic run_div(input string tag, input bit s,
                           input logic [31:0] a, input logic [31:0] b,
                           input int hold, input int win);
        logic [31:0] eq, er;
        logic [31:0] gq = '0;
        logic [31:0] gr = '0;
        int lat = 0;
        int pulses = 0;
        int exp_lat;
        ref_div(s, a, b, eq, er);
        exp_lat = (BYP && (b == 0 || is_ovf(s, a, b))) ? 1 : 33;
        @(negedge clk);
        dividend_i  = a;
        divisor_i   = b;
        is_signed_i = s;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        dividend_i  = $urandom;
        divisor_i   = $urandom;
        is_signed_i = 1'($urandom);
        if (hold <= 1) start_i = 1'b0;
        for (int e = 1; e <= win; e++) begin
            @(posedge clk);
            #1;
            if (e >= hold - 1) start_i = 1'b0;
            if (done_o) begin
                pulses++;
                if (lat == 0) begin
                    lat = e;
                    gq  = quotient_o;
                    gr  = remainder_o;
                end
            end
        end
        chk({tag, "/q"}, gq, eq);
        chk({tag, "/r"}, gr, er);
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/pulses"}, 32'(pulses), 32'd1);
        chk({tag, "/qhold"}, quotient_o, eq);
        chk({tag, "/rhold"}, remainder_o, er);
    endtask

    initial begin
        logic [31:0] a, b;
        bit s;
        int pulses;

        #1;
        chk("rst/q", quotient_o, 32'd0);
        chk("rst/r", remainder_o, 32'd0);
        chk("rst/done", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        run_div("s-103/20", 1, 32'hFFFF_FF99, 32'h14, 2, 40);
        run_div("s-10/-6", 1, 32'hFFFF_FFF6, 32'hFFFF_FFFA, 1, 40);
        run_div("s5/-3", 1, 32'd5, 32'hFFFF_FFFD, 1, 40);
        run_div("u10/3", 0, 32'd10, 32'd3, 1, 40);
        run_div("uffff/2", 0, 32'hFFFF_FFFF, 32'd2, 1, 40);
        run_div("u7/0", 0, 32'd7, 32'd0, 1, 40);
        run_div("s7/0", 1, 32'd7, 32'd0, 1, 40);
        run_div("s-7/0", 1, 32'hFFFF_FFF9, 32'd0, 1, 40);
        run_div("sovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 40);
        run_div("uovf", 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 40);
        // start kept high through the DONE cycle must not restart
        run_div("hold_done", 0, 32'd1000, 32'd7, 35, 75);

        // reset during a division
        @(negedge clk);
        dividend_i  = 32'd100;
        divisor_i   = 32'd7;
        is_signed_i = 1'b0;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset_i = 1'b1;
        #1;
        chk("midrst/q", quotient_o, 32'd0);
        chk("midrst/r", remainder_o, 32'd0);
        chk("midrst/done", 32'(done_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        pulses = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        chk("midrst/nopulse", 32'(pulses), 32'd0);
        run_div("post_rst10/3", 0, 32'd10, 32'd3, 1, 40);

        for (int i = 1; i <= 15; i++) begin
            for (int j = 0; j <= 15; j++) begin
                run_div($sformatf("sw%0d/%0d", i, j), 0, 32'(i), 32'(j),
                        1, 35);
            end
        end

        for (int k = 0; k < 120; k++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = -32'($urandom_range(1, 255));
                3: b = 32'($urandom_range(0, 1));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div($sformatf("rnd%0d", k), s, a, b,
                    int'($urandom_range(1, 3)), 35);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
